// File: rtl/mul_div_unit_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    localparam logic [1:0] MDU_IDLE = 2'b00;
    localparam logic [1:0] MDU_CALC = 2'b01;
    localparam logic [1:0] MDU_FIX  = 2'b10;

    function automatic logic op_is_iterative(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negation: absolute value on entry, sign restore on exit.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = neg ? (~val + WIDTH'(1)) : val;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers; one result bit per CALC cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Ainput,
    input  logic [WIDTH-1:0] Binput,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   rem_src, rem_fix, quo_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     add_sum, trial;
    logic [2*WIDTH-1:0] mul_step, div_step;

    assign a_neg = op_is_signed(op) & Ainput[WIDTH-1];
    assign b_neg = op_is_signed(op) & Binput[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.val(Ainput), .neg(a_neg), .res(a_abs));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.val(Binput), .neg(b_neg), .res(b_abs));

    // On divide-by-zero the latched |A| re-signed by the dividend sign recovers the original A.
    assign rem_src = dz_q ? a_q : acc_q[2*WIDTH-1:WIDTH];

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.val(acc_q), .neg(neg_res_q), .res(prod_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.val(acc_q[WIDTH-1:0]), .neg(neg_res_q), .res(quo_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.val(rem_src), .neg(neg_rem_q), .res(rem_fix));

    // Multiply: acc = {partial high, remaining multiplier bits}; add then shift right.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_step = {add_sum, acc_q[WIDTH-1:1]};
    end

    // Restoring divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    always_comb begin
        trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        if (!trial[WIDTH]) begin
            div_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (start && op_is_iterative(op)) begin
                    state_d   = MDU_CALC;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    a_d       = a_abs;
                    b_d       = b_abs;
                    dz_d      = (Binput == '0);
                    acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                end else if (start && op == MDU_MTHI) begin
                    hi_d = Ainput;
                end else if (start && op == MDU_MTLO) begin
                    lo_d = Ainput;
                end
            end
            MDU_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = is_div_q ? div_step : mul_step;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                state_d = MDU_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d       = rem_fix;
                    lo_d       = dz_q ? {WIDTH{1'b1}} : quo_fix;
                    div_zero_d = dz_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MDU_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q != MDU_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed checks of mul_div_unit at WIDTH=32 with hand-computed HI/LO results.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;

    // start/op/Ainput/Binput are driven on the falling edge and sampled by the DUT on the
    // rising edge; start is a one-cycle strobe, and busy=1 means further starts are ignored.
    logic         clock;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];

    mul_div_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .Ainput   (a_in),
        .Binput   (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // ---- clock / reset ----
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- driver: issue one iterative op, optionally disturb it while busy ----
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp, input bit disturb);
        int cyc;
        logic [2*W-1:0] e;
        exp_q.push_back(exp);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        forever begin
            if (disturb && cyc == 5) begin
                start = 1'b1;
                op    = MDU_DIV;
                a_in  = W'($urandom_range(1, 1000));
                b_in  = W'($urandom_range(1, 9));
            end else if (disturb && cyc == 6) begin
                start = 1'b0;
                op    = MDU_MTHI;
                a_in  = W'($urandom_range(1, 1000));
            end else if (disturb && cyc == 7) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (!busy) break;
            cyc++;
            if (cyc > 200) begin
                check({tag, " busy_timeout"}, 64'(busy), 64'(0));
                break;
            end
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 64'(cyc), 64'(W + 1));
        check({tag, " done_pulse"}, 64'(done), 64'(1));
        e = exp_q.pop_front();
        check({tag, " hi_lo"}, {hi, lo}, e);
        @(negedge clock);
        check({tag, " done_drop"}, 64'(done), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = MDU_MULT;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clock);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset div_zero", 64'(div_zero), 64'(0));
        check("reset hi_lo", {hi, lo}, 64'(0));
        check("reset state", 64'(dut.state_q), 64'(MDU_IDLE));
        rst_n = 1'b1;

        run_op("mult 7*-3", MDU_MULT, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op("mult -5*-6", MDU_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'd30, 0);
        run_op("multu max*max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("divu 100/7", MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        run_op("div min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
        check("div_zero after min/-1", 64'(div_zero), 64'(0));
        run_op("divu 55/0", MDU_DIVU, 32'd55, 32'd0, {32'd55, 32'hFFFF_FFFF}, 0);
        check("div_zero set", 64'(div_zero), 64'(1));
        run_op("mult 2*3 keeps dz", MDU_MULT, 32'd2, 32'd3, 64'd6, 0);
        check("div_zero kept by mult", 64'(div_zero), 64'(1));
        run_op("divu 9/3", MDU_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 0);
        check("div_zero cleared", 64'(div_zero), 64'(0));
        run_op("div -5/0", MDU_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0);
        check("div_zero signed", 64'(div_zero), 64'(1));

        // MTHI then MTLO on consecutive edges
        @(negedge clock);
        start = 1'b1;
        op    = MDU_MTHI;
        a_in  = 32'h1234;
        @(negedge clock);
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi busy_done", {62'd0, busy, done}, 64'(0));
        op   = MDU_MTLO;
        a_in = 32'h5678;
        @(negedge clock);
        start = 1'b0;
        check("mtlo hi_lo", {hi, lo}, {32'h1234, 32'h5678});
        check("mtlo busy_done", {62'd0, busy, done}, 64'(0));

        // undefined opcode is ignored
        @(negedge clock);
        start = 1'b1;
        op    = 3'b110;
        a_in  = 32'hDEAD;
        @(negedge clock);
        start = 1'b0;
        check("undef op busy", 64'(busy), 64'(0));
        check("undef op hi_lo", {hi, lo}, {32'h1234, 32'h5678});

        run_op("multu start while busy", MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1);

        // asynchronous reset in the middle of a multiply
        @(negedge clock);
        start = 1'b1;
        op    = MDU_MULT;
        a_in  = 32'h100;
        b_in  = 32'h100;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("mid-op busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'(0));
        check("async rst hi_lo", {hi, lo}, 64'(0));
        check("async rst state", 64'(dut.state_q), 64'(MDU_IDLE));
        @(negedge clock);
        rst_n = 1'b1;
        run_op("mult 3*4 after rst", MDU_MULT, 32'd3, 32'd4, 64'd12, 0);

        check("scoreboard empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
